// File: rtl/muladd_pkg.sv
// Shared types, constants and post-processing helpers for the muladd_array datapath.
package muladd_pkg;

   typedef enum logic [1:0] {
      ACT_NONE  = 2'd0,
      ACT_RELU  = 2'd1,
      ACT_LEAKY = 2'd2
   } act_e;

   localparam int unsigned OP_DELAY = 5;

   // Internal post-processing width; must exceed ACC_WIDTH+2.
   localparam int unsigned FW = 48;
   typedef logic signed [FW-1:0] wide_t;

   typedef struct packed {
      logic vld;
      logic eop;
   } beat_flag_t;

   // Arithmetic right shift with round-half-up; sh = 0 passes through.
   function automatic wide_t round_shift(input wide_t x, input int unsigned sh);
      wide_t half;
      if (sh == 0) return x;
      half = wide_t'(1) <<< (sh - 1);
      return (x + half) >>> sh;
   endfunction

   // Clamp to the signed range of a dw-bit value.
   function automatic wide_t saturate(input wide_t x, input int unsigned dw);
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (dw - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/muladd_lane.sv
// One output kernel: CPF multipliers, adder tree, frame accumulator and
// bias / requantise / activation / saturation post-processing.
module muladd_lane
   import muladd_pkg::*;
#(
   parameter int unsigned CPF        = 8,
   parameter int unsigned DIN_DW     = 8,
   parameter int unsigned WW         = 8,
   parameter int unsigned BIAS_DW    = 8,
   parameter int unsigned ACC_WIDTH  = 24,
   parameter int unsigned DOUT_DW    = 8,
   parameter int unsigned BIAS_SHIFT = 6,
   parameter int unsigned OUT_SHIFT  = 4,
   parameter int unsigned ACT_MODE   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CPF*DIN_DW-1:0]    din,
   input  logic [CPF*WW-1:0]        weight,
   input  logic [BIAS_DW-1:0]       bias,
   input  logic                     acc_en,
   input  logic                     acc_eop,
   input  logic                     post_en,
   input  logic                     out_en,
   output logic [DOUT_DW-1:0]       dout
);

   localparam int unsigned PW = DIN_DW + WW;
   localparam int unsigned SW = PW + $clog2(CPF);
   localparam act_e        ACT = act_e'(ACT_MODE[1:0]);

   logic signed [PW-1:0]        prod_d [CPF];
   logic signed [PW-1:0]        prod_q [CPF];
   logic signed [SW-1:0]        sum_d, sum_q;
   logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
   logic                        first_d, first_q;
   logic [BIAS_DW-1:0]          bias_pipe_d [3];
   logic [BIAS_DW-1:0]          bias_pipe_q [3];
   wide_t                       post_d, post_q;
   wide_t                       act_v;
   logic [DOUT_DW-1:0]          dout_d, dout_q;

   always_comb begin
      act_v   = post_q;
      sum_d   = '0;
      acc_d   = acc_q;
      first_d = first_q;
      post_d  = post_q;
      dout_d  = dout_q;

      for (int c = 0; c < CPF; c++) begin
         prod_d[c] = PW'($signed(din[c*DIN_DW +: DIN_DW])) * PW'($signed(weight[c*WW +: WW]));
      end
      for (int c = 0; c < CPF; c++) begin
         sum_d = sum_d + SW'(prod_q[c]);
      end

      // The beat following an eop (or reset) loads rather than adds.
      if (acc_en) begin
         acc_d   = first_q ? ACC_WIDTH'(sum_q) : acc_q + ACC_WIDTH'(sum_q);
         first_d = acc_eop;
      end

      bias_pipe_d[0] = bias;
      bias_pipe_d[1] = bias_pipe_q[0];
      bias_pipe_d[2] = bias_pipe_q[1];

      if (post_en) begin
         post_d = round_shift(wide_t'(acc_q) + (wide_t'($signed(bias_pipe_q[2])) <<< BIAS_SHIFT),
                              OUT_SHIFT);
      end

      if (out_en) begin
         if (post_q < 0) begin
            if (ACT == ACT_RELU)       act_v = '0;
            else if (ACT == ACT_LEAKY) act_v = post_q >>> 3;
         end
         dout_d = DOUT_DW'(saturate(act_v, DOUT_DW));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < CPF; c++) prod_q[c] <= '0;
         for (int i = 0; i < 3; i++) bias_pipe_q[i] <= '0;
         sum_q   <= '0;
         acc_q   <= '0;
         first_q <= 1'b1;
         post_q  <= '0;
         dout_q  <= '0;
      end else begin
         for (int c = 0; c < CPF; c++) prod_q[c] <= prod_d[c];
         for (int i = 0; i < 3; i++) bias_pipe_q[i] <= bias_pipe_d[i];
         sum_q   <= sum_d;
         acc_q   <= acc_d;
         first_q <= first_d;
         post_q  <= post_d;
         dout_q  <= dout_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/muladd_array.sv
// KPF-wide multiply-accumulate array: input capture, shared valid/eop pipeline,
// per-kernel lanes and the result strobe.
module muladd_array
   import muladd_pkg::*;
#(
   parameter int unsigned CPF        = 8,
   parameter int unsigned KPF        = 4,
   parameter int unsigned DIN_DW     = 8,
   parameter int unsigned WW         = 8,
   parameter int unsigned BIAS_DW    = 8,
   parameter int unsigned ACC_WIDTH  = 24,
   parameter int unsigned DOUT_DW    = 8,
   parameter int unsigned BIAS_SHIFT = 6,
   parameter int unsigned OUT_SHIFT  = 4,
   parameter int unsigned ACT_MODE   = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        op_din_en,
   input  logic                        op_din_eop,
   input  logic [CPF*DIN_DW-1:0]       op_din,
   input  logic [KPF*CPF*WW-1:0]       op_weight,
   input  logic [KPF*BIAS_DW-1:0]      op_bias,
   output logic [KPF*DOUT_DW-1:0]      op_dout,
   output logic                        op_dout_en
);

   // Flag stage indices: 0 input, 1 product, 2 tree, 3 accumulator, 4 post.
   localparam int unsigned STG_ACC  = 2;
   localparam int unsigned STG_POST = 3;
   localparam int unsigned STG_OUT  = OP_DELAY - 1;

   beat_flag_t                 flag_d [OP_DELAY];
   beat_flag_t                 flag_q [OP_DELAY];
   logic [CPF*DIN_DW-1:0]      din_d, din_q;
   logic [KPF*CPF*WW-1:0]      weight_d, weight_q;
   logic [KPF*BIAS_DW-1:0]     bias_d, bias_q;
   logic                       dout_en_d, dout_en_q;

   always_comb begin
      flag_d[0].vld = op_din_en;
      flag_d[0].eop = op_din_en & op_din_eop;
      for (int i = 1; i < OP_DELAY; i++) flag_d[i] = flag_q[i-1];

      din_d    = din_q;
      weight_d = weight_q;
      bias_d   = bias_q;
      if (op_din_en) begin
         din_d    = op_din;
         weight_d = op_weight;
      end
      if (op_din_en && op_din_eop) bias_d = op_bias;

      dout_en_d = flag_q[STG_OUT].vld & flag_q[STG_OUT].eop;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < OP_DELAY; i++) flag_q[i] <= '0;
         din_q     <= '0;
         weight_q  <= '0;
         bias_q    <= '0;
         dout_en_q <= 1'b0;
      end else begin
         for (int i = 0; i < OP_DELAY; i++) flag_q[i] <= flag_d[i];
         din_q     <= din_d;
         weight_q  <= weight_d;
         bias_q    <= bias_d;
         dout_en_q <= dout_en_d;
      end
   end

   for (genvar k = 0; k < KPF; k++) begin : g_lane
      muladd_lane #(
         .CPF        (CPF),
         .DIN_DW     (DIN_DW),
         .WW         (WW),
         .BIAS_DW    (BIAS_DW),
         .ACC_WIDTH  (ACC_WIDTH),
         .DOUT_DW    (DOUT_DW),
         .BIAS_SHIFT (BIAS_SHIFT),
         .OUT_SHIFT  (OUT_SHIFT),
         .ACT_MODE   (ACT_MODE)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .din     (din_q),
         .weight  (weight_q[k*CPF*WW +: CPF*WW]),
         .bias    (bias_q[k*BIAS_DW +: BIAS_DW]),
         .acc_en  (flag_q[STG_ACC].vld),
         .acc_eop (flag_q[STG_ACC].eop),
         .post_en (flag_q[STG_POST].vld & flag_q[STG_POST].eop),
         .out_en  (flag_q[STG_OUT].vld & flag_q[STG_OUT].eop),
         .dout    (op_dout[k*DOUT_DW +: DOUT_DW])
      );
   end

   assign op_dout_en = dout_en_q;

endmodule

// File: doc/muladd_array.md
# muladd_array

Parametrised multiply-accumulate datapath that computes KPF output channels in parallel, each over CPF input channels per beat. Products accumulate across a frame delimited by `op_din_eop`. At frame end it adds bias, requantises with rounding, applies a selectable activation, saturates, and emits a strobed result. It replaces paired per-kernel muladd instances and external weight interleaving inside conv layer tops, sitting between the row-buffer/weight-buffer reads and `blob_dout`.

## Interface
- CPF, 8, input channels consumed per beat
- KPF, 4, output kernels computed in parallel
- DIN_DW, 8, signed input element width
- WW, 8, signed weight width
- BIAS_DW, 8, signed bias width
- ACC_WIDTH, 24, accumulator width; two's-complement wrap, no saturation
- DOUT_DW, 8, signed output width
- BIAS_SHIFT, 6, left shift aligning bias to accumulator Q
- OUT_SHIFT, 4, arithmetic right shift for requantisation (0 allowed)
- ACT_MODE, 1, 0 = none, 1 = ReLU, 2 = leaky (negative >>> 3)
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-low
- op_din_en  in  1  beat valid
- op_din_eop  in  1  last beat of frame; qualified by op_din_en
- op_din  in  CPF*DIN_DW  channel c at bits [c*DIN_DW +: DIN_DW]
- op_weight  in  KPF*CPF*WW  kernel k, channel c at [(k*CPF+c)*WW +: WW]
- op_bias  in  KPF*BIAS_DW  kernel k at [k*BIAS_DW +: BIAS_DW]; sampled with the eop beat
- op_dout  out  KPF*DOUT_DW  kernel k at [k*DOUT_DW +: DOUT_DW]
- op_dout_en  out  1  one-cycle strobe, result valid

## Operation
- Beat: all KPF×CPF signed products, sum per kernel, sign-extend to ACC_WIDTH, accumulate.
- First beat after reset or after an eop beat loads the accumulator (no add). There is no separate clear.
- Beats with op_din_en=0 are bubbles: no accumulation, no state change.
- On an eop beat, the final accumulator value per kernel goes through post-processing:
  - s = acc + (sext(bias) << BIAS_SHIFT), computed in ACC_WIDTH+1 bits.
  - If OUT_SHIFT>0: r = (s + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (round-half-up). Otherwise r = s.
  - Activation per ACT_MODE: ReLU maps negative r to 0; leaky maps negative r to r >>> 3.
  - Saturate to [-2^(DOUT_DW-1), 2^(DOUT_DW-1)-1].
- op_dout holds the last result until the next strobe.
- No backpressure. The upstream controller spaces frames; single-beat frames (eop every beat) are legal.

## Timing
- Pipeline: products registered t+1, per-kernel adder tree t+2, accumulator t+3, bias/shift t+4, activation/saturate plus op_dout_en t+5.
- t is the edge sampling the beat. Fixed latency OP_DELAY = 5 from the eop beat to the op_dout_en strobe, independent of CPF/KPF.
- A valid/eop flag pipeline runs alongside the data. Bubbles propagate as invalid stages.
- Back-to-back eop beats give consecutive strobes with independent results.
- Reset values: op_dout = 0, op_dout_en = 0, accumulators = 0, all valid flags = 0.
- Reset mid-frame: the partial accumulation is discarded and no strobe is produced. The first beat after release starts a new frame.
- op_bias is read only on the eop beat and is delayed internally to t+4.

## Structure
- Package muladd_pkg holds:
  - ACT_NONE/ACT_RELU/ACT_LEAKY encodings
  - OP_DELAY constant
  - saturate and round-shift functions
- Sub-module muladd_lane computes one kernel: CPF multipliers, registered tree, accumulator, post-processing. It is instantiated KPF times.
- The top owns the shared valid/eop pipeline and the bus slicing.

## Test plan
- CPF=8, KPF=4, shifts 0, ReLU; one eop beat, din all 1, weights all 2, bias 0 -> op_dout_en exactly 5 cycles later, every lane = 16.
- 4-beat frame with bubbles between beats, din 3, weights 1, bias 1 with BIAS_SHIFT=0 -> each lane 97. No strobe before the 4th beat's t+5.
- din 127, weights 127, one beat (sum 129032) -> saturates to 127. Weights -1, din 5 (-40): ReLU -> 0, leaky -> -5, none -> -40.
- OUT_SHIFT=2: sum 6 -> 2, sum -6 -> -1, sum 5 -> 1 (round-half-up).
- eop on every cycle for 10 beats with varying data -> 10 consecutive strobes, each matching its single-beat reference value.
- Assert rst low after 2 beats of a 4-beat frame -> outputs 0 and no strobe. A new 1-beat frame after release produces a result excluding the pre-reset beats.
